// File: rtl/down_timer_pkg.sv
// Shared constants for the programmable down-counting timer: state encoding,
// mode encoding and the default data width.
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Programmable down-counting timer. Counts from a reload value down to zero,
// pulses TC for one cycle on the edge after zero is seen, and then either
// reloads (periodic) or returns to IDLE (one-shot). START, STOP and ENA give
// restart, abort and pause control. All outputs come straight from flops.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             LOAD,
  input  logic             START,
  input  logic             STOP,
  input  logic             ENA,
  input  logic             MODE,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             TC
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] start_value;

  // START with a simultaneous LOAD takes DataIn directly, so the new value
  // is used without waiting a cycle for the reload register to update.
  assign start_value = LOAD ? DataIn : reload;

  // Reload register: LOAD captures DataIn independently of the count/state
  // priority chain.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (RST) begin
      reload <= '0;
    end else if (LOAD) begin
      reload <= DataIn;
    end
  end

  // Control FSM and counter: RST > STOP > START > count, TC as a one-cycle
  // pulse that defaults low on every non-reset edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      Count <= '0;
      Busy  <= 1'b0;
      TC    <= 1'b0;
    end else begin
      TC <= 1'b0;
      if (STOP) begin
        // Abort: count is held where it was so software can read it back.
        state <= IDLE;
        Busy  <= 1'b0;
      end else if (START) begin
        // Start or restart; a restart never produces TC and ignores ENA.
        state <= RUN;
        Busy  <= 1'b1;
        Count <= start_value;
      end else if (state == RUN && ENA) begin
        if (Count != '0) begin
          // Zero is checked first, so this decrement can never underflow.
          Count <= Count - WIDTH'(1);
        end else begin
          TC <= 1'b1;
          if (MODE == MODE_PERIODIC) begin
            // Wrap uses the stored reload, so a LOAD during RUN lands here.
            Count <= reload;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios with constant
// expectations plus a randomized run against a period/elapsed-time model.
module tb_down_timer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] DataIn = '0;
  logic         LOAD = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         ENA = 1'b0;
  logic         MODE = 1'b0;
  logic [W-1:0] Count;
  logic         Busy;
  logic         TC;

  int checks = 0;
  int failures = 0;

  down_timer #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DataIn(DataIn),
    .LOAD  (LOAD),
    .START (START),
    .STOP  (STOP),
    .ENA   (ENA),
    .MODE  (MODE),
    .Count (Count),
    .Busy  (Busy),
    .TC    (TC)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle before sampling outputs.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    LOAD = 1'b0; START = 1'b0; STOP = 1'b0; RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD = 1'b1; START = 1'b1; DataIn = 8'hAA; ENA = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({Count, Busy, TC} !== {8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got count=%0d busy=%0b tc=%0b, want 0 0 0", Count, Busy, TC);
    end
  endtask

  task automatic test_reset_mid_run();
    MODE = 1'b0; ENA = 1'b1;
    DataIn = 8'd5; LOAD = 1'b1; tick(); LOAD = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    checks++;
    if ({Count, Busy} !== {8'd5, 1'b1}) begin
      failures++;
      $display("FAIL rst_run_start: got count=%0d busy=%0b, want 5 1", Count, Busy);
    end
    repeat (3) tick();
    checks++;
    if (Count !== 8'd2) begin
      failures++;
      $display("FAIL rst_run_count: got %0d, want 2", Count);
    end
    RST = 1'b1; tick(); RST = 1'b0;
    checks++;
    if ({Count, Busy, TC} !== {8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_run: got count=%0d busy=%0b tc=%0b, want 0 0 0", Count, Busy, TC);
    end
    // Reload was cleared too, so a bare START loads zero.
    START = 1'b1; tick(); START = 1'b0;
    checks++;
    if ({Count, Busy, TC} !== {8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_reload_cleared: got count=%0d busy=%0b tc=%0b, want 0 1 0", Count, Busy, TC);
    end
    tick();
    checks++;
    if ({Count, Busy, TC} !== {8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rst_zero_oneshot: got count=%0d busy=%0b tc=%0b, want 0 0 1", Count, Busy, TC);
    end
  endtask

  task automatic test_oneshot();
    MODE = 1'b0; ENA = 1'b1;
    DataIn = 8'd3; LOAD = 1'b1; tick(); LOAD = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      checks++;
      if ({Count, Busy, TC} !== {W'(i), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL oneshot_count: got count=%0d busy=%0b tc=%0b, want %0d 1 0", Count, Busy, TC, i);
      end
      if (i > 0) tick();
    end
    tick();
    checks++;
    if ({Count, Busy, TC} !== {8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL oneshot_tc: got count=%0d busy=%0b tc=%0b, want 0 0 1", Count, Busy, TC);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({Count, Busy, TC} !== {8'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL oneshot_after: got count=%0d busy=%0b tc=%0b, want 0 0 0", Count, Busy, TC);
      end
    end
  endtask

  task automatic test_periodic_pause();
    logic       ena_seq [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] cnt_seq [9] = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1};
    logic       tc_seq  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    MODE = 1'b1; ENA = 1'b1;
    DataIn = 8'd2; LOAD = 1'b1; tick(); LOAD = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    checks++;
    if ({Count, Busy} !== {8'd2, 1'b1}) begin
      failures++;
      $display("FAIL periodic_start: got count=%0d busy=%0b, want 2 1", Count, Busy);
    end
    for (int i = 0; i < 9; i++) begin
      ENA = ena_seq[i];
      tick();
      checks++;
      if ({Count, Busy, TC} !== {cnt_seq[i], 1'b1, tc_seq[i]}) begin
        failures++;
        $display("FAIL periodic_step%0d: got count=%0d busy=%0b tc=%0b, want %0d 1 %0b",
                 i, Count, Busy, TC, cnt_seq[i], tc_seq[i]);
      end
    end
    STOP = 1'b1; tick(); STOP = 1'b0;
    checks++;
    if ({Count, Busy, TC} !== {8'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop_in_run: got count=%0d busy=%0b tc=%0b, want 1 0 0", Count, Busy, TC);
    end
  endtask

  task automatic test_simultaneous();
    MODE = 1'b0; ENA = 1'b0;
    DataIn = 8'd7; LOAD = 1'b1; START = 1'b1; tick(); idle_inputs();
    checks++;
    if ({Count, Busy} !== {8'd7, 1'b1}) begin
      failures++;
      $display("FAIL load_start_bypass: got count=%0d busy=%0b, want 7 1", Count, Busy);
    end
    START = 1'b1; STOP = 1'b1; tick(); idle_inputs();
    checks++;
    if ({Count, Busy, TC} !== {8'd7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop_start: got count=%0d busy=%0b tc=%0b, want 7 0 0", Count, Busy, TC);
    end
  endtask

  task automatic test_restart();
    DataIn = 8'd9; MODE = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    ENA = 1'b1;
    repeat (6) tick();
    checks++;
    if (Count !== 8'd1) begin
      failures++;
      $display("FAIL restart_pre: got %0d, want 1", Count);
    end
    // Restart while paused: ENA must not matter; stored reload (7) is used.
    ENA = 1'b0; START = 1'b1; tick(); START = 1'b0;
    checks++;
    if ({Count, Busy, TC} !== {8'd7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL restart_run: got count=%0d busy=%0b tc=%0b, want 7 1 0", Count, Busy, TC);
    end
    STOP = 1'b1; tick(); STOP = 1'b0;
  endtask

  task automatic test_wrap();
    int tc_seen = 0;
    MODE = 1'b1; ENA = 1'b1;
    DataIn = 8'd255; LOAD = 1'b1; tick(); LOAD = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    for (int k = 1; k <= 768; k++) begin
      tick();
      if (TC) tc_seen++;
      checks++;
      if ({Count, TC} !== {W'(255 - (k % 256)), (k % 256) == 0}) begin
        failures++;
        $display("FAIL wrap_k%0d: got count=%0d tc=%0b, want %0d %0b",
                 k, Count, TC, 255 - (k % 256), (k % 256) == 0);
      end
    end
    checks++;
    if (tc_seen != 3) begin
      failures++;
      $display("FAIL wrap_tc_total: got %0d pulses, want 3", tc_seen);
    end
    STOP = 1'b1; tick(); STOP = 1'b0;
  endtask

  // Model: the timer is described by the period start value n and the number
  // of enabled cycles elapsed since it was loaded; Count is n - elapsed.
  task automatic test_random();
    int m_reload, m_n, m_elapsed;
    bit m_run, m_tc;
    int bad = 0;
    RST = 1'b1; tick(); RST = 1'b0;
    m_reload = 0; m_n = 0; m_elapsed = 0; m_run = 0;
    for (int c = 0; c < 3000; c++) begin
      RST    = ($urandom_range(0, 99) == 0);
      STOP   = ($urandom_range(0, 19) == 0);
      START  = ($urandom_range(0, 9) == 0);
      LOAD   = ($urandom_range(0, 7) == 0);
      ENA    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) MODE = ~MODE;
      DataIn = W'($urandom_range(0, 12));
      tick();
      m_tc = 0;
      if (RST) begin
        m_reload = 0; m_n = 0; m_elapsed = 0; m_run = 0;
      end else begin
        if (STOP) begin
          m_run = 0;
        end else if (START) begin
          m_n = LOAD ? int'(DataIn) : m_reload;
          m_elapsed = 0;
          m_run = 1;
        end else if (m_run && ENA) begin
          if (m_elapsed < m_n) begin
            m_elapsed++;
          end else begin
            m_tc = 1;
            if (MODE) begin
              m_n = m_reload;
              m_elapsed = 0;
            end else begin
              m_run = 0;
            end
          end
        end
        if (LOAD) m_reload = int'(DataIn);
      end
      checks++;
      if ({Count, Busy, TC} !== {W'(m_n - m_elapsed), m_run, m_tc}) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_c%0d: got count=%0d busy=%0b tc=%0b, want %0d %0b %0b",
                   c, Count, Busy, TC, m_n - m_elapsed, m_run, m_tc);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    tick();
    test_reset();
    test_reset_mid_run();
    test_oneshot();
    test_periodic_pause();
    test_simultaneous();
    test_restart();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_down_timer
